// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Imported by the interface, the baud counter and the top level.
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int UART_CLKS_PER_BIT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_t;

  // The baud counter only runs while a serial frame is on the line.
  function automatic logic in_frame(input uart_state_t s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side signals of the UART transmitter.
// master = the transmitter, slave = the FIFO / pin environment.
interface fifo_uart_tx_if;
  import uart_pkg::*;

  logic                   tx_en;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_data;
  logic                   fifo_rd;
  logic                   tx;
  logic                   busy;

  modport master (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output tx,
    output busy
  );

  modport slave (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  tx,
    input  busy
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last count.
// Held at zero while i_clr is high so every frame starts on a fresh period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_done = w_last && !i_clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and sends each as an 8N1 frame, LSB first.
// All outputs come straight from registers.
//
// state | meaning
// IDLE  | line high; wait for non-empty FIFO with tx_en
// RD    | one-cycle fifo_rd strobe
// WAIT  | FIFO presents data; captured into shift register on exit
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high) for one bit period
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.master bus
);

  uart_state_t            r_state;
  logic [UART_DATA_W-1:0] r_shreg;
  logic [2:0]             r_bit_idx;
  logic                   r_tx;
  logic                   r_fifo_rd;
  logic                   r_busy;

  logic                   w_bit_done;
  logic                   w_cnt_clr;

  assign w_cnt_clr = !in_frame(r_state);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk        (clk),
    .rst        (reset),
    .i_clr      (w_cnt_clr),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_fifo_rd <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_fifo_rd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!bus.fifo_empty && bus.tx_en) begin
            r_state   <= ST_RD;
            r_fifo_rd <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_RD: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_shreg   <= bus.fifo_data;
          r_bit_idx <= '0;
          r_tx      <= 1'b0;
          r_state   <= ST_START;
        end
        ST_START: begin
          if (w_bit_done) begin
            r_tx    <= r_shreg[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            // index wraps back to 0 after bit 7, ready for the next frame
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shreg <= {1'b0, r_shreg[UART_DATA_W-1:1]};
              r_tx    <= r_shreg[1];
            end
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx      = r_tx;
  assign bus.fifo_rd = r_fifo_rd;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue-backed FIFO model with registered read data,
// and frame capture on the serial line sampled on the falling clock edge.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fifo_uart_tx_if bus();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic       wr_en   = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic [7:0] q[$];
  int         cyc          = 0;
  int         rd_cnt       = 0;
  int         rd_empty_cnt = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  // FIFO model: read data registered one cycle after fifo_rd, empty flag registered.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      if (q.size() == 0) begin
        rd_empty_cnt <= rd_empty_cnt + 1;
      end else begin
        bus.fifo_data <= q[0];
        void'(q.pop_front());
      end
    end
    if (wr_en) q.push_back(wr_byte);
    bus.fifo_empty <= (q.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_byte = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int t);
    int n;
    n = 0;
    while (bus.tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, 32'(bus.tx === 1'b0), 32'd1);
    t = cyc;
  endtask

  // Called on the first low sample of the start bit; consumes 10*CPB samples.
  task automatic recv(output logic [7:0] b, output int glitches);
    logic first;
    glitches = 0;
    b        = 8'h00;
    first    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        if (j == 0) first = bus.tx;
        else if (bus.tx !== first) glitches++;
        if (k == 0 && bus.tx !== 1'b0) glitches++;
        if (k == 9 && bus.tx !== 1'b1) glitches++;
        if (k >= 1 && k <= 8 && j == 1) b[k-1] = bus.tx;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t_rd, t_s, t_prev, base, bad, g;
    logic [7:0] b;
    logic [7:0] hola [4];
    hola[0] = 8'h68; hola[1] = 8'h6F; hola[2] = 8'h6C; hola[3] = 8'h61;

    // reset and idle
    bus.tx_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_tx",   32'(bus.tx),      32'd1);
    chk("rst_busy", 32'(bus.busy),    32'd0);
    chk("rst_rd",   32'(bus.fifo_rd), 32'd0);
    reset     = 1'b0;
    bus.tx_en = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd !== 1'b0) bad++;
    end
    chk("idle_100_bad", 32'(bad), 32'd0);
    chk("idle_no_rd",   32'(rd_cnt), 32'd0);

    // single byte written into an empty, idle FIFO
    push(8'h68);
    chk("wr_empty_low", 32'(bus.fifo_empty), 32'd0);
    chk("wr_no_early_rd", 32'(bus.fifo_rd), 32'd0);
    @(negedge clk);
    chk("h_rd_e0",   32'(bus.fifo_rd), 32'd1);
    chk("h_busy_e0", 32'(bus.busy),    32'd1);
    t_rd = cyc;
    @(negedge clk);
    chk("h_rd_pulse_end", 32'(bus.fifo_rd), 32'd0);
    wait_start("h", t_s);
    chk("h_start_lat", 32'(t_s - t_rd), 32'd2);
    recv(b, g);
    chk("h_byte",   32'(b), 32'h68);
    chk("h_glitch", 32'(g), 32'd0);
    @(negedge clk);
    chk("h_busy_end", 32'(bus.busy), 32'd0);
    chk("h_tx_end",   32'(bus.tx),   32'd1);
    chk("h_rd_count", 32'(rd_cnt),   32'd1);

    // "hola" queued while disabled, then released
    bus.tx_en = 1'b0;
    for (int i = 0; i < 4; i++) push(hola[i]);
    repeat (3) @(negedge clk);
    base = rd_cnt;
    chk("hola_no_rd_disabled", 32'(rd_cnt), 32'd1);
    bus.tx_en = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_start("hola", t_s);
      if (i > 0) chk("hola_spacing", 32'(t_s - t_prev), 32'd43);
      t_prev = t_s;
      recv(b, g);
      chk("hola_byte",   32'(b), 32'(hola[i]));
      chk("hola_glitch", 32'(g), 32'd0);
    end
    @(negedge clk);
    chk("hola_busy_fall", 32'(bus.busy), 32'd0);
    repeat (60) @(negedge clk);
    chk("hola_rd_count", 32'(rd_cnt - base), 32'd4);
    chk("hola_busy_idle", 32'(bus.busy), 32'd0);

    // tx_en dropped mid-frame
    bus.tx_en = 1'b0;
    push(8'h41);
    push(8'h42);
    base = rd_cnt;
    bus.tx_en = 1'b1;
    wait_start("en", t_s);
    bus.tx_en = 1'b0;
    recv(b, g);
    chk("en_byte1",  32'(b), 32'h41);
    chk("en_glitch", 32'(g), 32'd0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) bad++;
    end
    chk("en_line_quiet", 32'(bad), 32'd0);
    chk("en_rd_held",    32'(rd_cnt - base), 32'd1);
    chk("en_busy_low",   32'(bus.busy), 32'd0);
    bus.tx_en = 1'b1;
    wait_start("en2", t_s);
    recv(b, g);
    chk("en_byte2",    32'(b), 32'h42);
    chk("en_rd_total", 32'(rd_cnt - base), 32'd2);

    // reset during DATA bit 3
    push(8'h55);
    push(8'hA3);
    base = rd_cnt;
    wait_start("rst", t_s);
    repeat (17) @(negedge clk);
    chk("rst_bit3_tx",   32'(bus.tx),   32'd0);
    chk("rst_bit3_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_tx",   32'(bus.tx),      32'd1);
    chk("rst_mid_busy", 32'(bus.busy),    32'd0);
    chk("rst_mid_rd",   32'(bus.fifo_rd), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_start("rst2", t_s);
    recv(b, g);
    chk("rst_next_byte",   32'(b), 32'hA3);
    chk("rst_next_glitch", 32'(g), 32'd0);
    chk("rst_rd_total",    32'(rd_cnt - base), 32'd2);
    chk("no_empty_reads",  32'(rd_empty_cnt), 32'd0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain-side consumer for the byte FIFO. Whenever the FIFO is non-empty and transmission is enabled, it pops one byte, serializes it as an 8N1 UART frame (LSB first) on `tx`, and repeats until the FIFO is empty. It sits between the FIFO read port and the board serial pin. It is the reading end of the path that the text producers write into.

## Interface
- `CLKS_PER_BIT`, 4: clocks per serial bit. Must be ≥ 2. The bench uses 4; synthesis sets it to clk/baud.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `tx_en` input 1: permits starting a new frame. Sampled only in IDLE.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_data` input 8: FIFO registered read data. Valid the cycle after `fifo_rd`.
- `fifo_rd` output 1: one-cycle read strobe to the FIFO.
- `tx` output 1: serial line. Idle level is high.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Single clock domain. Reset is asynchronous and active-high.
- All outputs are registered, so there is no combinational path from any input to any output.
- States and transitions:
  - IDLE: if `!fifo_empty && tx_en`, go to RD. Otherwise stay in IDLE.
  - RD: `fifo_rd`=1 for exactly this one cycle. Go to WAIT.
  - WAIT: the FIFO presents data. On the exit edge, load `fifo_data` into an 8-bit shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT clocks. Go to DATA.
  - DATA: `tx`=shreg[0] for CLKS_PER_BIT clocks per bit, then shift right. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT clocks. Go to IDLE.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on every state change.
  - Bit index is 3 bits and wraps at 7, which ends the DATA state.
- `tx_en` deasserted mid-frame: the current frame completes. No new RD is issued.
- `fifo_rd` is issued only from IDLE after sampling `!fifo_empty`. It is therefore never asserted into an empty FIFO, and at most one read is outstanding.
- Writes to the FIFO during a frame do not affect the frame in progress.
- Reset mid-frame:
  - Immediately: `tx`=1, `fifo_rd`=0, `busy`=0, state IDLE, counters and shift register cleared.
  - The byte being shifted is lost. FIFO contents are untouched.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, shift register 0x00.
- Let E0 be the edge at which IDLE samples a non-empty FIFO with `tx_en`=1:
  - `fifo_rd` is high from E0 to E0+1.
  - `tx` falls (start bit) at E0+2.
  - Frame length is 10×CLKS_PER_BIT clocks.
  - `tx` stays high from the end of the stop bit until the next start bit.
- Back-to-back frames: 3 extra high clocks (IDLE, RD, WAIT) follow each stop bit. The frame period is 10×CLKS_PER_BIT+3 clocks.
- `busy` rises at E0 and falls at the edge that ends the stop bit.

## Structure
- Shared package `uart_pkg`:
  - state encoding enum (IDLE, RD, WAIT, START, DATA, STOP)
  - `UART_DATA_W`=8
  - default `CLKS_PER_BIT`
- Sub-module `uart_baud_cnt`:
  - counter with synchronous clear and wrap
  - emits `bit_done` on its last count
  - parameterized by CLKS_PER_BIT
- The top level holds the FSM, shift register, bit index and output registers.

## Test plan
- **Reset idle:** hold `reset`=1, then release with the FIFO empty. Required: `tx`=1, `busy`=0, `fifo_rd`=0 for 100 clocks.
- **Single byte "h" (0x68), CLKS_PER_BIT=4:**
  - `fifo_rd` pulses exactly once.
  - `tx` carries start 0, then bits 0,0,0,1,0,1,1,0, then stop 1.
  - Each bit lasts 4 clocks and the frame is 40 clocks.
  - The start bit begins 2 clocks after the first edge that sees non-empty.
- **"hola" queued:**
  - Exactly 4 `fifo_rd` pulses.
  - Frames decode to 0x68, 0x6F, 0x6C, 0x61 in order.
  - Frame-to-frame start spacing is 43 clocks.
  - `busy` falls after the last stop bit, and there is no fifth read.
- **`tx_en` dropped mid-frame:** the frame completes intact, then there are no further `fifo_rd` pulses. Re-raising `tx_en` resumes transmission with the next byte.
- **Reset asserted during DATA bit 3:**
  - `tx`=1 and `busy`=0 immediately.
  - After release, the next byte from the FIFO is sent as a complete, correct frame.
- **Write while empty-and-idle:** one byte written into an empty FIFO. Required: `fifo_rd` occurs the first edge after `fifo_empty` deasserts, and no spurious reads occur before it.
